// File: rtl/ram_copy_ctrl.sv
// Block-copy initiator for the single-port RAM: alternating read/write cycles
// move len words from src to dst in ascending order and accumulate a checksum.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// RD    | present source address (src+i) for a read
// WR    | write the word just read to dst+i, accumulate checksum
// FIN   | one-cycle done pulse, then back to IDLE
module ram_copy_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     i_q, i_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [DATA_W-1:0]   checksum_q, checksum_d;
    logic [ADDR_W:0]     i_inc;

    // i is one bit wider than an address so len = 2^ADDR_W terminates correctly
    assign i_inc    = i_q + {{ADDR_W{1'b0}}, 1'b1};
    assign checksum = checksum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            i_q        <= '0;
            len_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            len_q      <= len_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            checksum_q <= checksum_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        len_d      = len_q;
        src_d      = src_q;
        dst_d      = dst_q;
        checksum_d = checksum_q;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_din    = '0;
        busy       = 1'b1;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    src_d      = src_addr;
                    dst_d      = dst_addr;
                    len_d      = len;
                    i_d        = '0;
                    checksum_d = '0;
                    state_d    = (len == '0) ? FIN : RD;
                end
            end
            RD: begin
                ram_addr = src_q + i_q[ADDR_W-1:0];
                state_d  = WR;
            end
            WR: begin
                ram_we     = 1'b1;
                ram_addr   = dst_q + i_q[ADDR_W-1:0];
                ram_din    = ram_dout;
                checksum_d = checksum_q + ram_dout;
                i_d        = i_inc;
                state_d    = (i_inc == len_q) ? FIN : RD;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_copy_ctrl.sv
// Bench for ram_copy_ctrl: RAM model plus array-level forward-copy reference.
module tb_ram_copy_ctrl;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] src_addr, dst_addr;
    logic [AW:0]   len;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout, checksum;
    logic          busy, done;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem     [MS];
    logic [DW-1:0] exp_mem [MS];
    logic [DW-1:0] rd_val  [MS];

    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    ram_copy_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered read; preload port used only while idle.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ram_we) mem[ram_addr] <= ram_din;
        else ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = AW'(a);
        pre_data = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    // abort_wr > 0: assert rst at the edge closing that many WR cycles.
    task automatic run_copy(input int s, input int d, input int n, input int abort_wr);
        int n_eff, c, done_c, busy_n, we_n, errs, j, mism;
        bit aborted;
        logic [DW-1:0] sum;
        logic [AW:0] len_v;
        n_eff = (abort_wr > 0 && abort_wr < n) ? abort_wr : n;
        sum = '0;
        for (int k = 0; k < MS; k++) exp_mem[k] = mem[k];
        for (int k = 0; k < n_eff; k++) begin
            rd_val[k] = exp_mem[(s + k) % MS];
            exp_mem[(d + k) % MS] = rd_val[k];
            sum = sum + rd_val[k];
        end
        for (int k = n_eff; k < n; k++) rd_val[k] = exp_mem[(s + k) % MS];

        len_v = (AW+1)'(n);
        @(negedge clk);
        start = 1'b1; src_addr = AW'(s); dst_addr = AW'(d); len = len_v;
        @(posedge clk);
        #1;
        src_addr = AW'($urandom_range(0, MS-1));
        dst_addr = AW'($urandom_range(0, MS-1));
        len      = (AW+1)'($urandom_range(0, MS));

        c = 0; done_c = 0; busy_n = 0; we_n = 0; errs = 0; aborted = 1'b0;
        while (done_c == 0 && c < 2*n + 6 && !aborted) begin
            @(negedge clk);
            c++;
            if (busy) busy_n++;
            if (ram_we) we_n++;
            if (done) begin
                done_c = c;
                if (ram_we !== 1'b0 || ram_addr !== '0 || ram_din !== '0) errs++;
            end else if (c <= 2*n) begin
                j = (c - 1) / 2;
                if (c % 2 == 1) begin
                    if (ram_we !== 1'b0 || ram_addr !== AW'((s + j) % MS) || ram_din !== '0) errs++;
                end else begin
                    if (ram_we !== 1'b1 || ram_addr !== AW'((d + j) % MS) || ram_din !== rd_val[j]) errs++;
                end
            end
            if (abort_wr > 0 && c == 2*abort_wr) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("abort_busy", busy, 0);
                check("abort_checksum", checksum, 0);
                check("abort_we", ram_we, 0);
                rst = 1'b0;
                aborted = 1'b1;
            end
            if (c == 1) begin
                @(posedge clk);
                #1 start = 1'b0;
            end
        end

        check("cycle_trace", errs, 0);
        if (aborted) begin
            check("abort_we_count", we_n, abort_wr);
            we_n = 0; done_c = 0;
            for (int k = 0; k < 2*n + 4; k++) begin
                @(negedge clk);
                if (ram_we) we_n++;
                if (done) done_c++;
            end
            check("abort_no_write", we_n, 0);
            check("abort_no_done", done_c, 0);
        end else begin
            check("done_cycle", done_c, 2*n + 1);
            check("busy_cycles", busy_n, 2*n + 1);
            check("we_cycles", we_n, n);
            check("checksum", checksum, sum);
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("checksum_hold", checksum, sum);
        end
        mism = 0;
        for (int k = 0; k < MS; k++) if (mem[k] !== exp_mem[k]) mism++;
        check("mem_image", mism, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", ram_we, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_din", ram_din, 0);
        check("rst_checksum", checksum, 0);
        rst = 1'b0;

        for (int k = 0; k < MS; k++) preload(k, $urandom);

        for (int k = 0; k < 4; k++) preload(10 + k, DW'(k + 1));
        run_copy(10, 100, 4, 0);
        for (int k = 0; k < 4; k++) check("basic_word", mem[100 + k], k + 1);
        check("basic_sum", checksum, 10);

        preload(1022, 32'hA); preload(1023, 32'hB); preload(0, 32'hC);
        run_copy(1022, 500, 3, 0);
        check("wrap_sum", checksum, 32'h21);
        check("wrap_word", mem[502], 32'hC);

        run_copy($urandom_range(0, MS-1), $urandom_range(0, MS-1), 0, 0);
        check("zero_sum", checksum, 0);

        preload(0, 32'hFFFF_FFFF); preload(1, 32'hFFFF_FFFF);
        run_copy(0, 8, 2, 0);
        check("ovf_sum", checksum, 32'hFFFF_FFFE);

        run_copy(20, 300, 8, 0);
        run_copy(30, 400, 8, 2);
        run_copy(40, 600, 8, 0);

        // rst wins over a simultaneous start
        @(negedge clk);
        rst = 1'b1; start = 1'b1; src_addr = 5; dst_addr = 6; len = 4;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_prio_busy", busy, 0);
        @(negedge clk);
        check("rst_prio_idle", busy, 0);

        for (int k = 0; k < 4; k++) preload(k, DW'(5 + k));
        run_copy(0, 1, 3, 0);
        for (int k = 0; k < 4; k++) check("overlap_word", mem[k], 5);

        run_copy($urandom_range(0, MS-1), $urandom_range(0, MS-1), MS, 0);

        repeat (6) run_copy($urandom_range(0, MS-1), $urandom_range(0, MS-1),
                            $urandom_range(0, 40), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_copy_ctrl.md
RAM_COPY_CTRL -- requirements
Module: ram_copy_ctrl

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, default 10, RAM address width.
- DATA_W, default 32, RAM word width.
REQ-002 Ports SHALL be, in order:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a block copy; sampled only in IDLE.
- src_addr  in  ADDR_W  first source word address.
- dst_addr  in  ADDR_W  first destination word address.
- len  in  ADDR_W+1  word count, 0..2^ADDR_W.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_dout  in  DATA_W  RAM registered read data.
- busy  out  1  copy in progress.
- done  out  1  one-cycle completion pulse.
- checksum  out  DATA_W  sum of copied words.
REQ-003 The block SHALL be the initiator for the team's single-port RAM. That RAM has the following behaviour:
- A read with ram_we=0 updates ram_dout at the posedge.
- A write with ram_we=1 does not change ram_dout.
- Read data is therefore valid in the cycle after the address is presented.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, RD, WR, FIN.
REQ-005 In IDLE, start=1 SHALL do all of the following at that edge:
- Latch src_addr, dst_addr and len.
- Clear the word index i and checksum to 0.
- Go to RD if len!=0, otherwise go to FIN.
REQ-006 In RD, ram_we SHALL be 0 and ram_addr SHALL equal (src+i) mod 2^ADDR_W; the next state SHALL be WR.
REQ-007 In WR, the outputs SHALL be:
- ram_we=1.
- ram_addr=(dst+i) mod 2^ADDR_W.
- ram_din=ram_dout, i.e. the data read in the preceding RD.
REQ-008 At the WR edge, the block SHALL:
- Set checksum to (checksum+ram_dout) mod 2^DATA_W.
- Increment i.
- Go to FIN if i+1==len, otherwise go to RD.
REQ-009 In FIN, done SHALL be 1 for exactly that cycle; the next state SHALL be IDLE.
REQ-010 busy SHALL be 1 in RD, WR and FIN, and 0 in IDLE.
REQ-011 Copy timing: with start accepted at edge k and len=N>0, the block SHALL occupy 2N RD/WR cycles, and done SHALL be high in cycle k+2N+1 counted from cycle k+1.
REQ-012 When len=0, done SHALL pulse in the cycle after acceptance, ram_we SHALL stay 0 and checksum SHALL be 0.
REQ-013 start SHALL be ignored while busy=1.
REQ-014 src_addr, dst_addr and len changes after acceptance SHALL have no effect on the current copy.
REQ-015 Address arithmetic SHALL wrap modulo 2^ADDR_W; len=2^ADDR_W SHALL copy the whole memory.
REQ-016 The copy SHALL be strictly ascending from index 0; overlapping ranges are not detected. With dst>src and overlap, the result is the defined forward-copy result, in which overwritten source words propagate.
REQ-017 checksum SHALL hold its final value from FIN until the next accepted start.
REQ-018 Outside WR, ram_din SHALL be 0.
REQ-019 Outside RD and WR, ram_addr SHALL be 0.

Reset
REQ-020 While rst=1 at a posedge, the block SHALL:
- Enter IDLE.
- Set ram_we=0, ram_addr=0, ram_din=0, busy=0, done=0, checksum=0 and i=0.
REQ-021 rst SHALL take priority over start.
REQ-022 A reset in mid-copy SHALL abort the copy:
- No further RAM write occurs after the reset edge.
- done does not pulse for the aborted copy.
- Words already written stay written.

Verification
REQ-023 Basic copy: preload RAM[10..13]=1,2,3,4; start with src=10, dst=100, len=4 -> RAM[100..103]=1,2,3,4; done high in cycle 9 after acceptance; checksum=10; busy high for 9 cycles.
REQ-024 Wrap-around: preload RAM[1022]=0xA, RAM[1023]=0xB, RAM[0]=0xC; start with src=1022, dst=500, len=3 -> RAM[500..502]=0xA,0xB,0xC; checksum=0x21.
REQ-025 Zero length: start with len=0 -> done in the next cycle; no cycle has ram_we=1; checksum=0.
REQ-026 Checksum overflow: preload RAM[0]=RAM[1]=0xFFFFFFFF; start with src=0, dst=8, len=2 -> checksum=0xFFFFFFFE.
REQ-027 Busy and reset: during a len=8 copy, pulse start with new arguments -> copy unaffected. On a second run, assert rst after exactly 2 WR cycles -> only dst+0 and dst+1 written; done never pulses; a following start works normally.
REQ-028 Forward overlap: preload RAM[0..3]=5,6,7,8; start with src=0, dst=1, len=3 -> RAM[0..3]=5,5,5,5.
